serial_adder_sequencer: RTL and testbench
=========================================

// Module: serial_adder_sequencer
// PURPOSE
//  Multi-cycle add/subtract engine. Adds two NIBBLES*4-bit operands by time-sharing one
//  4-bit ripple-carry adder (AdderRippleCarry_4b_GL), one nibble per cycle, LSB first.
//  A carry register links the cycles. Requests and responses use val/rdy handshakes.
//  Sits between the lab datapath and the gate-level adder as its sequencer.
// PARAMETERS
//  NIBBLES   4   operand width in nibbles; W = 4*NIBBLES; legal range 1..8
// PORTS
//  clk        in   1  clock; all state updates on the rising edge
//  reset      in   1  asynchronous, active-low reset (0 = reset)
//  req_val    in   1  request valid
//  req_rdy    out  1  block can accept a request
//  req_in0    in   W  operand A
//  req_in1    in   W  operand B
//  req_cin    in   1  carry-in for add; ignored for sub
//  req_sub    in   1  0 = A+B+cin; 1 = A+~B+1 (A-B)
//  resp_val   out  1  result valid
//  resp_rdy   in   1  consumer accepts result
//  resp_sum   out  W  result, modulo 2^W
//  resp_cout  out  1  carry out of bit W-1 (for sub: 1 = no borrow)
//  resp_ovf   out  1  two's-complement signed overflow
// BEHAVIOUR
//  - Reset (reset==0): asynchronous return to IDLE. Clears carry reg, nibble counter,
//    operand regs and result regs to 0.
//    Output values in reset: req_rdy=0, resp_val=0, resp_sum=0, resp_cout=0, resp_ovf=0.
//  - FSM states: IDLE, CALC, DONE.
//    IDLE: req_rdy=1. On req_val&&req_rdy, latch the operands:
//      a   <= in0
//      b   <= in1 ^ {W{sub}}
//      c   <= sub ? 1 : cin
//      cnt <= 0
//      go to CALC.
//    CALC: adder inputs are a[3:0], b[3:0] and c. At each edge:
//      res <= {adder_sum, res[W-1:4]}
//      c   <= adder_cout
//      a   <= a>>4;  b <= b>>4
//      cnt <= cnt+1
//      When cnt==NIBBLES-1, go to DONE and register resp_cout=adder_cout and resp_ovf.
//    DONE: resp_val=1. Outputs are held stable until resp_val&&resp_rdy, then go to IDLE.
//  - Latency: handshake in cycle 0 -> CALC in cycles 1..NIBBLES -> resp_val in cycle
//    NIBBLES+1 (cycle 5 for the default).
//    Minimum request spacing is NIBBLES+2 cycles. IDLE never accepts in the same cycle
//    as a response handshake.
//  - req_rdy=0 in CALC and DONE. req_val in those states is ignored and does not stall
//    anything. Operands are sampled only at the handshake; later input changes have no effect.
//  - Overflow: ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the
//    inverted B for sub. Compute it from the MSBs held during the last CALC cycle.
//  - NIBBLES==1: exactly one CALC cycle. The counter is at least 1 bit wide.
//  - Reset mid-CALC or mid-DONE: the operation is aborted and no response is produced.
//    After release, the block is in IDLE with req_rdy=1.
//  - resp_rdy held high in DONE: resp_val stays high for exactly one cycle.
// STRUCTURE
//  - Shared package (sas_pkg):
//      state typedef enum {IDLE, CALC, DONE}
//      localparams OP_ADD=1'b0 and OP_SUB=1'b1
//  - Sub-module: one instance of AdderRippleCarry_4b_GL; no other adder logic.
//  - Sequential logic: always_ff with async negedge reset. Next-state and output
//    logic in separate always_comb blocks.
// TESTING (default NIBBLES=4)
//  1. Basic add after reset: 0x1234 + 0x0001, cin=0
//     -> resp_val in cycle 5; sum=0x1235, cout=0, ovf=0.
//  2. Ripple across all nibbles:
//     - 0xFFFF + 0x0001 -> sum=0x0000, cout=1, ovf=0
//     - 0x7FFF + 0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1
//  3. Subtract:
//     - 0x0005 - 0x0007 -> sum=0xFFFE, cout=0, ovf=0
//     - 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1
//  4. Backpressure: hold resp_rdy=0 for 3 cycles in DONE while req_val=1 with new operands
//     -> resp outputs stable, req_rdy=0; after resp_rdy=1, IDLE next cycle and the new
//     request is accepted.
//  5. Reset mid-CALC: pulse reset=0 in cycle 2 of 0xAAAA+0x5555
//     -> all outputs 0 during reset; no resp_val afterwards. Then 0x0F0F+0x00F1 -> 0x1000.
//  6. Random: 50 operations with random in0, in1, cin, sub and random resp_rdy stalls,
//     checked against a {cout,sum} = in0 + (sub ? ~in1+1 : in1+cin) model.

Source files
------------

// File: rtl/sas_pkg.sv
// Shared types and constants for the serial add/subtract sequencer.
package sas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_sequencer_adder.sv
// 4-bit ripple-carry adder built from explicit per-bit gate equations.
module AdderRippleCarry_4b_GL (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] carry;
    logic [3:0] half;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign half[i]      = a_i[i] ^ b_i[i];
        assign sum_o[i]     = half[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & half[i]);
    end

    assign cout_o = carry[4];

endmodule

// File: rtl/serial_adder_sequencer.sv
// Multi-cycle add/subtract engine: one shared 4-bit adder processes one nibble
// per cycle, LSB first, with val/rdy handshakes on request and response.
module serial_adder_sequencer
    import sas_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [4*NIBBLES-1:0] req_in0,
    input  logic [4*NIBBLES-1:0] req_in1,
    input  logic                 req_cin,
    input  logic                 req_sub,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [4*NIBBLES-1:0] resp_sum,
    output logic                 resp_cout,
    output logic                 resp_ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       add_sum;
    logic             add_cout;
    logic [W-1:0]     res_shift;

    AdderRippleCarry_4b_GL u_adder (
        .a_i    (a_q[3:0]),
        .b_i    (b_q[3:0]),
        .cin_i  (c_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // The newest nibble enters at the top so the LSB nibble ends up at bit 0.
    if (NIBBLES == 1) begin : g_res_one
        assign res_shift = add_sum;
    end else begin : g_res_many
        assign res_shift = {add_sum, res_q[W-1:4]};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_val)            state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST)  state_d = DONE;
            DONE:    if (resp_rdy)           state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a hold default first so no path infers a latch.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (req_val) begin
                    a_d   = req_in0;
                    b_d   = req_in1 ^ {W{req_sub}};
                    c_d   = (req_sub == OP_SUB) ? 1'b1 : req_cin;
                    cnt_d = '0;
                end
            end
            CALC: begin
                res_d = res_shift;
                c_d   = add_cout;
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // In the last cycle a_q[3]/b_q[3] are the operand sign bits.
                    cout_d = add_cout;
                    ovf_d  = (a_q[3] == b_q[3]) && (add_sum[3] != a_q[3]);
                end
            end
            default: ;
        endcase
    end

    // NOTE: state and datapath registers all use non-blocking assignments and are
    // cleared by the asynchronous reset so an aborted operation leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // req_rdy is gated by reset so the block never advertises readiness while held in reset.
    always_comb begin
        req_rdy  = reset && (state_q == IDLE);
        resp_val = (state_q == DONE);
    end

    assign resp_sum  = res_q;
    assign resp_cout = cout_q;
    assign resp_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed and random checks of serial_adder_sequencer at NIBBLES=4.
module tb_serial_adder_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_val, req_rdy;
    logic [W-1:0] req_in0, req_in1;
    logic         req_cin, req_sub;
    logic         resp_val, resp_rdy;
    logic [W-1:0] resp_sum;
    logic         resp_cout, resp_ovf;

    int errors = 0;
    int checks = 0;

    serial_adder_sequencer #(.NIBBLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_sum  (resp_sum),
        .resp_cout (resp_cout),
        .resp_ovf  (resp_ovf)
    );

    always #5 clk = ~clk;

    // Waits in IDLE, performs one request handshake, returns at the negedge of cycle 1.
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        int n = 0;
        while (req_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL req_rdy_wait: req_rdy=%b required 1", req_rdy);
        end
        req_val = 1'b1;
        req_in0 = a;
        req_in1 = b;
        req_cin = cin;
        req_sub = sub;
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
        req_in0 = ~a;
        req_in1 = W'($urandom);
        req_cin = ~cin;
        req_sub = ~sub;
    endtask

    // Counts cycles (handshake = cycle 0) until resp_val; bounded.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (resp_val !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                              input logic exp_cout, input logic exp_ovf, input int stall);
        int cyc;
        send_req(a, b, cin, sub);
        wait_resp(cyc);
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL %s latency: got cycle %0d required 5", name, cyc);
        end
        repeat (stall) @(negedge clk);
        checks++;
        if (resp_val !== 1'b1 || resp_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s sum: val=%b sum=%h required val=1 sum=%h", name, resp_val, resp_sum, exp_sum);
        end
        checks++;
        if (resp_cout !== exp_cout || resp_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s flags: cout=%b ovf=%b required cout=%b ovf=%b",
                     name, resp_cout, resp_ovf, exp_cout, exp_ovf);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_rdy = 1'b0;
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s release: resp_val=%b req_rdy=%b required 0/1", name, resp_val, req_rdy);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        req_val  = 1'b0;
        req_in0  = '0;
        req_in1  = '0;
        req_cin  = 1'b0;
        req_sub  = 1'b0;
        resp_rdy = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b0 || resp_val !== 1'b0 || resp_sum !== 16'h0000 ||
            resp_cout !== 1'b0 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b val=%b sum=%h cout=%b ovf=%b required all 0",
                     req_rdy, resp_val, resp_sum, resp_cout, resp_ovf);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_rdy=%b resp_val=%b required 1/0", req_rdy, resp_val);
        end
    endtask

    task automatic test_basic();
        run_vector("basic_add", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 0);
    endtask

    task automatic test_ripple();
        run_vector("ripple_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_vector("ripple_cin",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    endtask

    task automatic test_subtract();
        run_vector("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
        run_vector("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        int cyc;
        send_req(16'h0100, 16'h0200, 1'b0, 1'b0);
        wait_resp(cyc);
        req_val = 1'b1;
        req_in0 = 16'h1111;
        req_in1 = 16'h2222;
        req_cin = 1'b0;
        req_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_val !== 1'b1 || resp_sum !== 16'h0300 || resp_cout !== 1'b0 ||
                resp_ovf !== 1'b0 || req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: val=%b sum=%h cout=%b ovf=%b rdy=%b required 1/0300/0/0/0",
                         i, resp_val, resp_sum, resp_cout, resp_ovf, req_rdy);
            end
            @(negedge clk);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_rdy = 1'b0;
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: req_rdy=%b resp_val=%b required 1/0", req_rdy, resp_val);
        end
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
        wait_resp(cyc);
        checks++;
        if (cyc !== 5 || resp_sum !== 16'h3333) begin
            errors++;
            $display("FAIL bp_next: cycle=%0d sum=%h required 5/3333", cyc, resp_sum);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int seen = 0;
        send_req(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b0 || resp_val !== 1'b0 || resp_sum !== 16'h0000 ||
            resp_cout !== 1'b0 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b val=%b sum=%h cout=%b ovf=%b required all 0",
                     req_rdy, resp_val, resp_sum, resp_cout, resp_ovf);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rdy: req_rdy=%b required 1", req_rdy);
        end
        for (int i = 0; i < 8; i++) begin
            if (resp_val === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_noresp: resp_val seen %0d cycles required 0", seen);
        end
        run_vector("after_reset", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int high = 0;
        resp_rdy = 1'b1;
        send_req(16'h4000, 16'h4000, 1'b0, 1'b0);
        wait_resp(cyc);
        checks++;
        if (cyc !== 5 || resp_sum !== 16'h8000 || resp_ovf !== 1'b1 || resp_cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: cycle=%0d sum=%h cout=%b ovf=%b required 5/8000/0/1",
                     cyc, resp_sum, resp_cout, resp_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            if (resp_val === 1'b1) high++;
            @(negedge clk);
        end
        checks++;
        if (high != 1) begin
            errors++;
            $display("FAIL b2b_pulse: resp_val high %0d cycles required 1", high);
        end
        resp_rdy = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, bb, s;
        logic         cin, sub, co, ov;
        logic [W:0]   full;
        for (int n = 0; n < 50; n++) begin
            a    = W'($urandom);
            b    = W'($urandom);
            cin  = 1'($urandom);
            sub  = 1'($urandom);
            bb   = sub ? ~b : b;
            full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
            s    = full[W-1:0];
            co   = full[W];
            ov   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
            run_vector($sformatf("rand%0d", n), a, b, cin, sub, s, co, ov, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_subtract();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
